// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy encoding, default widths and control-field offsets for pipeline stages
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_occ_e;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 8;

    // MEM/WB control-field bit positions inside the ctrl vector
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_PCSRC    = 2;
    localparam int CTRL_WA3_LSB  = 3;
    localparam int CTRL_WA3_MSB  = 6;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating up-counter with variable increment and synchronous active-low reset
module pipe_sat_cnt #(
    parameter int CNT_W = 16,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   sum;

    // One spare bit catches overflow so the counter sticks at all-ones
    assign sum = {1'b0, cnt_q} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    assign cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (sum[CNT_W]) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with 2-entry skid, flush and bubble-safe ctrl; stats under PIPE_STAGE_STATS_EN
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_occ_e         state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic              in_ready_q;
    logic              main_vld, accept, drain;
    logic              load_main_in, load_skid_in, load_main_skid;

    // Entry valid bits are decoded from occupancy so they can never disagree with it
    assign main_vld  = (state_q != EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign drain     = main_vld && out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_vld ? main_ctrl_q : '0;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (load_main_in) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid_in) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] held_cnt;
    logic [1:0] flush_inc;

    // A flush discards every held entry plus the beat being offered alongside it
    always_comb begin
        held_cnt  = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
        flush_inc = flush ? (held_cnt + {1'b0, in_valid}) : 2'd0;
    end

    pipe_sat_cnt #(.CNT_W(CNT_W), .INC_W(2)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ({1'b0, main_vld && !out_ready}),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W), .INC_W(2)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - table, directed and randomized checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } beat_t;

    typedef struct {
        logic              r, f, iv;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic              ordy;
        logic              e_irdy, e_ovld;
        logic [DATA_W-1:0] e_data;
        logic [CTRL_W-1:0] e_ctrl;
        logic              e_chk_data;
    } vec_t;

    beat_t mq[$];
    int    m_stall, m_flush;
    int    vectors, errors;
    vec_t  tbl[26];

    function automatic vec_t mk(input logic r, f, iv, input logic [DATA_W-1:0] d,
                                input logic [CTRL_W-1:0] c, input logic ordy,
                                input logic e_irdy, e_ovld, input logic [DATA_W-1:0] e_data,
                                input logic [CTRL_W-1:0] e_ctrl, input logic e_chk_data);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_data = e_data;
        v.e_ctrl = e_ctrl; v.e_chk_data = e_chk_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, f, iv, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy);
        reset = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        #1;
    endtask

    task automatic model_check();
        check("model in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check("model out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("model out_data", 64'(out_data), 64'(mq[0].d));
            check("model out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
        end else begin
            check("model out_ctrl bubble", 64'(out_ctrl), 64'd0);
        end
`ifdef PIPE_STAGE_STATS_EN
        check("model stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("model flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // Advance one clock, updating the FIFO model from the inputs held across the edge
    task automatic tick();
        bit acc, drn;
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if (!reset) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && !out_ready) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
            if (flush) begin
                m_flush = m_flush + mq.size() + int'(in_valid);
                if (m_flush > CNT_MAX) m_flush = CNT_MAX;
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back('{d: in_data, c: in_ctrl});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; errors = 0; m_stall = 0; m_flush = 0;

        //             r f iv data    ctrl   or | irdy ovld data    ctrl chk
        tbl[0]  = mk(0, 0, 1, 'hAA,  'h11, 1,  1, 0, 'h00, 'h00, 1);
        tbl[1]  = mk(1, 0, 1, 'h01,  'h01, 1,  1, 0, 'h00, 'h00, 1);
        tbl[2]  = mk(1, 0, 1, 'h02,  'h01, 1,  1, 1, 'h01, 'h01, 1);
        tbl[3]  = mk(1, 0, 1, 'h03,  'h01, 1,  1, 1, 'h02, 'h01, 1);
        tbl[4]  = mk(1, 0, 0, 'h00,  'h00, 1,  1, 1, 'h03, 'h01, 1);
        tbl[5]  = mk(1, 0, 1, 'h0A,  'h22, 0,  1, 0, 'h00, 'h00, 0);
        tbl[6]  = mk(1, 0, 1, 'h0B,  'h33, 0,  1, 1, 'h0A, 'h22, 1);
        tbl[7]  = mk(1, 0, 1, 'h0C,  'h44, 0,  0, 1, 'h0A, 'h22, 1);
        tbl[8]  = mk(1, 0, 1, 'h0C,  'h44, 1,  0, 1, 'h0A, 'h22, 1);
        tbl[9]  = mk(1, 0, 1, 'h0C,  'h44, 1,  1, 1, 'h0B, 'h33, 1);
        tbl[10] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 1, 'h0C, 'h44, 1);
        tbl[11] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 0, 'h00, 'h00, 0);
        tbl[12] = mk(1, 0, 1, 'h10,  'h55, 0,  1, 0, 'h00, 'h00, 0);
        tbl[13] = mk(1, 0, 1, 'h11,  'h66, 0,  1, 1, 'h10, 'h55, 1);
        tbl[14] = mk(1, 1, 1, 'hDD,  'h77, 0,  0, 1, 'h10, 'h55, 1);
        tbl[15] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 0, 'h00, 'h00, 0);
        tbl[16] = mk(1, 0, 1, 'h20,  'hFF, 1,  1, 0, 'h00, 'h00, 0);
        tbl[17] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 1, 'h20, 'hFF, 1);
        tbl[18] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 0, 'h00, 'h00, 0);
        tbl[19] = mk(1, 0, 1, 'h30,  'h01, 1,  1, 0, 'h00, 'h00, 0);
        tbl[20] = mk(1, 1, 0, 'h00,  'h00, 1,  1, 1, 'h30, 'h01, 1);
        tbl[21] = mk(1, 0, 0, 'h00,  'h00, 1,  1, 0, 'h00, 'h00, 0);
        tbl[22] = mk(1, 0, 1, 'h40,  'h02, 0,  1, 0, 'h00, 'h00, 0);
        tbl[23] = mk(1, 0, 1, 'h41,  'h03, 0,  1, 1, 'h40, 'h02, 1);
        tbl[24] = mk(0, 1, 1, 'h42,  'h04, 0,  0, 1, 'h40, 'h02, 1);
        tbl[25] = mk(1, 0, 0, 'h00,  'h00, 0,  1, 0, 'h00, 'h00, 1);

        drive(0, 0, 1, 'h0, 'h0, 1);
        tick();

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
            check($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].e_irdy));
            check($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].e_ovld));
            check($sformatf("tbl[%0d] out_ctrl", i), 64'(out_ctrl), 64'(tbl[i].e_ctrl));
            if (tbl[i].e_chk_data)
                check($sformatf("tbl[%0d] out_data", i), 64'(out_data), 64'(tbl[i].e_data));
`ifdef PIPE_STAGE_STATS_EN
            if (i == 15) check("flush_cnt after TWO flush", 64'(flush_cnt), 64'd3);
`endif
            model_check();
            tick();
        end

        // Streaming: one beat per cycle, each visible one cycle after acceptance
        drive(0, 0, 0, 'h0, 'h0, 1);
        tick();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) drive(1, 0, 1, DATA_W'(i), 'h01, 1);
            else        drive(1, 0, 0, 'h0, 'h0, 1);
            check($sformatf("stream in_ready %0d", i), 64'(in_ready), 64'd1);
            if (i > 1) check($sformatf("stream out_data %0d", i), 64'(out_data), 64'(i - 1));
            model_check();
            tick();
        end

`ifdef PIPE_STAGE_STATS_EN
        drive(0, 0, 0, 'h0, 'h0, 0);
        tick();
        drive(1, 0, 1, 'h5A, 'h0F, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 'h0, 'h0, 0);
            model_check();
            tick();
        end
        check("stall_cnt saturates", 64'(stall_cnt), 64'(CNT_MAX));
`endif

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, DATA_W'($urandom), CTRL_W'($urandom),
                  $urandom_range(0, 1) == 1);
            model_check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
